// File: rtl/l1d_package.sv
// L1D shared types and constants for the MSHR allocation path.
package l1d_package;

    localparam int L1D_MSHR_ENTRY_NUM = 8;
    localparam int L1D_MSHR_ID_WIDTH  = $clog2(L1D_MSHR_ENTRY_NUM);
    localparam int L1D_MSHR_REQ_NUM   = 3;

    localparam int L1D_REQ_LD = 0;
    localparam int L1D_REQ_ST = 1;
    localparam int L1D_REQ_PF = 2;

    typedef enum logic [1:0] {
        MSHR_FREE = 2'd0,
        MSHR_RSVD = 2'd1,
        MSHR_BUSY = 2'd2
    } mshr_state_e;

endpackage

// File: rtl/cmn_rr_arb.sv
// Round-robin arbiter: first valid requester at or after ptr wins.
module cmn_rr_arb #(
    parameter  int REQ_NUM = 3,
    localparam int PW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic [REQ_NUM-1:0] vld_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [REQ_NUM-1:0] gnt_oh_o,
    output logic [PW-1:0]      gnt_idx_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < REQ_NUM; off++) begin
            idx = (int'(ptr_i) + off) % REQ_NUM;
            if (!found && vld_i[idx]) begin
                found          = 1'b1;
                gnt_oh_o[idx]  = 1'b1;
                gnt_idx_o      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/l1d_mshr_alloc_ctrl.sv
// MSHR entry lifecycle owner: feeds pre_allocator, hands its ids to
// miss requesters round-robin, and frees entries on refill release.
module l1d_mshr_alloc_ctrl
    import l1d_package::*;
#(
    parameter  int REQ_NUM = L1D_MSHR_REQ_NUM,
    localparam int PW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int EN      = L1D_MSHR_ENTRY_NUM,
    localparam int IW      = L1D_MSHR_ID_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] v_req_vld,
    output logic [REQ_NUM-1:0] v_req_rdy,
    output logic               rsp_vld,
    output logic [REQ_NUM-1:0] rsp_req_oh,
    output logic [IW-1:0]      rsp_id,
    output logic [EN-1:0]      v_pa_free_vld,
    input  logic [EN-1:0]      v_pa_free_rdy,
    input  logic               pa_id_vld,
    output logic               pa_id_rdy,
    input  logic [IW-1:0]      pa_id,
    input  logic               rel_vld,
    input  logic [IW-1:0]      rel_id,
    output logic [EN-1:0]      v_mshr_busy,
    output logic               mshr_full,
    output logic               err_rel
);

    mshr_state_e        state_q [EN];
    mshr_state_e        state_d [EN];
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [REQ_NUM-1:0] rsp_req_oh_q, rsp_req_oh_d;
    logic [IW-1:0]      rsp_id_q, rsp_id_d;
    logic               err_rel_q, err_rel_d;

    logic               grant;
    logic [REQ_NUM-1:0] arb_oh;
    logic [PW-1:0]      arb_idx;

    cmn_rr_arb #(.REQ_NUM(REQ_NUM)) u_arb (
        .vld_i     (v_req_vld),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    assign grant     = pa_id_vld && (|v_req_vld);
    assign pa_id_rdy = grant;
    assign v_req_rdy = grant ? arb_oh : '0;

    always_comb begin
        v_pa_free_vld = '0;
        v_mshr_busy   = '0;
        for (int i = 0; i < EN; i++) begin
            v_pa_free_vld[i] = (state_q[i] == MSHR_FREE);
            v_mshr_busy[i]   = (state_q[i] == MSHR_BUSY);
        end
    end

    assign mshr_full = !pa_id_vld && (v_pa_free_vld == '0);

    // Grant forces BUSY even on an illegal id so the entry cannot leak.
    always_comb begin
        for (int i = 0; i < EN; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == MSHR_FREE && v_pa_free_rdy[i])
                state_d[i] = MSHR_RSVD;
            if (grant && pa_id == IW'(i))
                state_d[i] = MSHR_BUSY;
            if (rel_vld && rel_id == IW'(i) && state_q[i] == MSHR_BUSY)
                state_d[i] = MSHR_FREE;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rsp_vld_d    = grant;
        rsp_req_oh_d = rsp_req_oh_q;
        rsp_id_d     = rsp_id_q;
        err_rel_d    = err_rel_q;
        if (grant) begin
            rr_ptr_d     = (arb_idx == PW'(REQ_NUM - 1)) ? '0 : arb_idx + PW'(1);
            rsp_req_oh_d = arb_oh;
            rsp_id_d     = pa_id;
        end
        if (rel_vld && state_q[rel_id] != MSHR_BUSY)
            err_rel_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < EN; i++)
                state_q[i] <= MSHR_FREE;
            rr_ptr_q     <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_req_oh_q <= '0;
            rsp_id_q     <= '0;
            err_rel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_req_oh_q <= rsp_req_oh_d;
            rsp_id_q     <= rsp_id_d;
            err_rel_q    <= err_rel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && grant)
            assert (state_q[pa_id] == MSHR_RSVD);
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_req_oh = rsp_req_oh_q;
    assign rsp_id     = rsp_id_q;
    assign err_rel    = err_rel_q;

endmodule

// File: tb/tb_l1d_mshr_alloc_ctrl.sv
// Directed bench for l1d_mshr_alloc_ctrl with hand-computed expectations.
module tb_l1d_mshr_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] v_req_vld;
    logic [2:0] v_req_rdy;
    logic       rsp_vld;
    logic [2:0] rsp_req_oh;
    logic [2:0] rsp_id;
    logic [7:0] v_pa_free_vld;
    logic [7:0] v_pa_free_rdy;
    logic       pa_id_vld;
    logic       pa_id_rdy;
    logic [2:0] pa_id;
    logic       rel_vld;
    logic [2:0] rel_id;
    logic [7:0] v_mshr_busy;
    logic       mshr_full;
    logic       err_rel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l1d_mshr_alloc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .v_req_vld     (v_req_vld),
        .v_req_rdy     (v_req_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_req_oh    (rsp_req_oh),
        .rsp_id        (rsp_id),
        .v_pa_free_vld (v_pa_free_vld),
        .v_pa_free_rdy (v_pa_free_rdy),
        .pa_id_vld     (pa_id_vld),
        .pa_id_rdy     (pa_id_rdy),
        .pa_id         (pa_id),
        .rel_vld       (rel_vld),
        .rel_id        (rel_id),
        .v_mshr_busy   (v_mshr_busy),
        .mshr_full     (mshr_full),
        .err_rel       (err_rel)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reserve(input int i);
        v_pa_free_rdy = 8'(1 << i);
        tick();
        v_pa_free_rdy = '0;
    endtask

    task automatic idle();
        v_req_vld = '0;
        pa_id_vld = 1'b0;
        pa_id     = '0;
    endtask

    logic [2:0] rr_ids [3];
    logic [2:0] rr_oh  [3];
    logic [2:0] full_ids [3];

    initial begin
        rst = 1'b1;
        v_pa_free_rdy = '0;
        rel_vld = 1'b0;
        rel_id  = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_free", v_pa_free_vld, 8'hFF);
        chk("rst_busy", v_mshr_busy, 8'h00);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_oh", rsp_req_oh, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_err", err_rel, 0);
        chk("rst_rdy", v_req_rdy, 0);
        chk("rst_pa_rdy", pa_id_rdy, 0);
        chk("rst_full", mshr_full, 0);

        reserve(2);
        chk("rsv2_free", v_pa_free_vld, 8'hFB);
        v_req_vld = 3'b001;
        pa_id_vld = 1'b1;
        pa_id     = 3'd2;
        #1;
        chk("single_rdy", v_req_rdy, 3'b001);
        chk("single_pa_rdy", pa_id_rdy, 1);
        tick();
        idle();
        chk("single_rsp_vld", rsp_vld, 1);
        chk("single_rsp_oh", rsp_req_oh, 3'b001);
        chk("single_rsp_id", rsp_id, 2);
        chk("single_busy", v_mshr_busy, 8'h04);

        // rr_ptr is 1 after the grant to requester 0
        reserve(0);
        reserve(1);
        reserve(3);
        rr_ids[0] = 3'd0; rr_oh[0] = 3'b010;
        rr_ids[1] = 3'd1; rr_oh[1] = 3'b100;
        rr_ids[2] = 3'd3; rr_oh[2] = 3'b001;
        v_req_vld = 3'b111;
        pa_id_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pa_id = rr_ids[k];
            #1;
            chk($sformatf("rr%0d_rdy", k), v_req_rdy, rr_oh[k]);
            tick();
            chk($sformatf("rr%0d_rsp_vld", k), rsp_vld, 1);
            chk($sformatf("rr%0d_rsp_oh", k), rsp_req_oh, rr_oh[k]);
            chk($sformatf("rr%0d_rsp_id", k), rsp_id, rr_ids[k]);
        end
        idle();
        chk("rr_busy", v_mshr_busy, 8'h0F);

        reserve(4);
        v_req_vld = 3'b101;
        pa_id_vld = 1'b1;
        pa_id     = 3'd4;
        #1;
        chk("skip_rdy", v_req_rdy, 3'b100);
        tick();
        idle();
        chk("skip_rsp_oh", rsp_req_oh, 3'b100);
        chk("skip_busy", v_mshr_busy, 8'h1F);

        reserve(5);
        v_req_vld = 3'b001;
        pa_id_vld = 1'b1;
        pa_id     = 3'd5;
        #1;
        chk("wrap_rdy", v_req_rdy, 3'b001);
        tick();
        idle();
        chk("g5_busy", v_mshr_busy, 8'h3F);

        rel_vld = 1'b1;
        rel_id  = 3'd5;
        tick();
        rel_vld = 1'b0;
        chk("rel5_busy", v_mshr_busy, 8'h1F);
        chk("rel5_free", v_pa_free_vld, 8'hE0);
        chk("rel5_err", err_rel, 0);
        reserve(5);
        chk("rsv5_free", v_pa_free_vld, 8'hC0);

        reserve(6);
        reserve(7);
        full_ids[0] = 3'd5;
        full_ids[1] = 3'd6;
        full_ids[2] = 3'd7;
        for (int k = 0; k < 3; k++) begin
            v_req_vld = 3'b001;
            pa_id_vld = 1'b1;
            pa_id     = full_ids[k];
            #1;
            chk($sformatf("fill%0d_rdy", k), v_req_rdy, 3'b001);
            tick();
        end
        pa_id_vld = 1'b0;
        v_req_vld = 3'b001;
        #1;
        chk("full_busy", v_mshr_busy, 8'hFF);
        chk("full_flag", mshr_full, 1);
        chk("full_rdy", v_req_rdy, 0);
        chk("full_pa_rdy", pa_id_rdy, 0);
        tick();
        chk("full_flag2", mshr_full, 1);
        chk("full_rsp_vld", rsp_vld, 0);
        rel_vld = 1'b1;
        rel_id  = 3'd3;
        tick();
        rel_vld = 1'b0;
        chk("unfull_flag", mshr_full, 0);
        chk("unfull_busy", v_mshr_busy, 8'hF7);
        chk("unfull_free", v_pa_free_vld, 8'h08);
        chk("unfull_rdy", v_req_rdy, 0);

        rel_vld = 1'b1;
        rel_id  = 3'd3;
        tick();
        rel_vld = 1'b0;
        chk("err_set", err_rel, 1);
        chk("err_free", v_pa_free_vld, 8'h08);
        chk("err_busy", v_mshr_busy, 8'hF7);
        tick();
        chk("err_sticky", err_rel, 1);

        reserve(3);
        v_req_vld = 3'b010;
        pa_id_vld = 1'b1;
        pa_id     = 3'd3;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("mrst_rsp_vld", rsp_vld, 0);
        chk("mrst_rsp_id", rsp_id, 0);
        chk("mrst_busy", v_mshr_busy, 8'h00);
        chk("mrst_free", v_pa_free_vld, 8'hFF);
        chk("mrst_err", err_rel, 0);

        reserve(0);
        v_req_vld = 3'b101;
        pa_id_vld = 1'b1;
        pa_id     = 3'd0;
        #1;
        chk("mrst_ptr_rdy", v_req_rdy, 3'b001);
        tick();
        idle();
        chk("mrst_rsp_oh", rsp_req_oh, 3'b001);
        chk("mrst_busy2", v_mshr_busy, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule
